// File: rtl/dump_pkg.sv
// Shared types and defaults for the register dump unit.
package dump_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } dump_state_t;

  localparam int NUM_REGS_DEFAULT      = 32;
  localparam int BYTES_PER_REG_DEFAULT = 4;

endpackage

// File: rtl/register_dump_unit_word_serializer.sv
// Loads one register word and emits it LSB-first as bytes over valid/ready.
module word_serializer
  import dump_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NBYTES = BYTES_PER_REG_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [7:0]       byte_o,
  output logic             valid_o,
  output logic             fire_o,
  output logic             last_o
);

  localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;

  assign byte_o  = shift_q[7:0];
  assign valid_o = valid_q;
  assign fire_o  = valid_q && ready_i;
  assign last_o  = (cnt_q == CNT_W'(NBYTES - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      shift_d = data_i;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (fire_o) begin
      shift_d = shift_q >> 8;
      if (last_o) begin
        // valid drops only here, so a presented byte is never withdrawn
        cnt_d   = '0;
        valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/register_dump_unit.sv
// Walks x0..x(NUM_REGS-1) on the debug read port and streams each word to the UART.
//   state | meaning
//   IDLE  | waiting for dump_start_i
//   LATCH | debug address driven, word captured into the serializer
//   SEND  | bytes of the current word handed to the transmitter
//   DONE  | one-cycle completion pulse
module register_dump_unit
  import dump_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEFAULT,
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 soft_reset_i,
  input  logic                 dump_start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [4:0]           rs_dbg_addr_o,
  input  logic [REG_WIDTH-1:0] rs_dbg_data_i,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i
);

  localparam int         BYTES_PER_REG = REG_WIDTH / 8;
  localparam logic [4:0] LAST_IDX      = 5'(NUM_REGS - 1);

  dump_state_t state_q, state_d;
  logic [4:0]  reg_idx_q, reg_idx_d;
  logic        load;
  logic        fire;
  logic        last_byte;

  word_serializer #(
    .WIDTH  (REG_WIDTH),
    .NBYTES (BYTES_PER_REG)
  ) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (soft_reset_i),
    .load_i  (load),
    .data_i  (rs_dbg_data_i),
    .ready_i (tx_ready_i),
    .byte_o  (tx_data_o),
    .valid_o (tx_valid_o),
    .fire_o  (fire),
    .last_o  (last_byte)
  );

  assign rs_dbg_addr_o = reg_idx_q;

  always_ff @(posedge clk) begin
    if (!rst_n || soft_reset_i) begin
      state_q   <= IDLE;
      reg_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      reg_idx_q <= reg_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    reg_idx_d = reg_idx_q;
    unique case (state_q)
      IDLE: begin
        if (dump_start_i) begin
          reg_idx_d = '0;
          state_d   = LATCH;
        end
      end
      LATCH: state_d = SEND;
      SEND: begin
        if (fire && last_byte) begin
          // DONE is taken at the last index, so reg_idx never wraps
          if (reg_idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            reg_idx_d = reg_idx_q + 5'd1;
            state_d   = LATCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != IDLE);
    done_o = (state_q == DONE);
    load   = (state_q == LATCH);
  end

endmodule
